// File: rtl/rv_pkg.sv
// Shared types for the RV32I integer pipeline.
// Write-back source select and the default datapath width.
package rv_pkg;

    localparam int RV_XLEN = 32;

    typedef enum logic [1:0] {
        WB_MEM = 2'b00,
        WB_ALU = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one busy bit per register plus
// a registered count of how many registers are pending.
module reg_scoreboard import rv_pkg::*; #(
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_rd,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_rd,
    output logic [NREGS-1:0] busy,
    output logic             iss_busy,
    output logic [AW:0]      pend_cnt
);

    logic             set;
    logic             clr;
    logic             inc;
    logic             dec;
    logic [NREGS-1:0] busy_nxt;

    // Next busy vector; an issue overrides a same-cycle load return.
    always_comb begin
        set      = iss_en && (iss_rd != '0);
        clr      = wb_en && (wb_rd != '0);
        busy_nxt = busy;
        if (clr) busy_nxt[wb_rd] = 1'b0;
        if (set) busy_nxt[iss_rd] = 1'b1;
        inc = set && !busy[iss_rd];
        dec = clr && busy[wb_rd] && !(set && (iss_rd == wb_rd));
    end

    assign iss_busy = busy[iss_rd];

    // Busy bits and pending count; reset drops every outstanding load.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            unique case ({inc, dec})
                2'b10:   pend_cnt <= pend_cnt + 1'b1;
                2'b01:   pend_cnt <= pend_cnt - 1'b1;
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Integer register file with two write ports, same-cycle
// write-to-read bypass and a pending-load scoreboard.
module regfile_bypass_sb import rv_pkg::*; #(
    parameter int XLEN   = RV_XLEN,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter bit BYPASS = 1'b1,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   rs_addr,
    output logic [NREAD*XLEN-1:0] rs_data,
    output logic [NREAD-1:0]      rs_busy,
    input  logic                  wa_en,
    input  logic [AW-1:0]         wa_rd,
    input  logic [1:0]            wa_sel,
    input  logic [XLEN-1:0]       wa_alu,
    input  logic [XLEN-1:0]       wa_pc4,
    input  logic [XLEN-1:0]       wa_imm,
    input  logic [XLEN-1:0]       wa_mem,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_rd,
    output logic                  iss_busy,
    output logic [AW:0]           pend_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [XLEN-1:0]  wa_data;
    logic [NREGS-1:0] busy;
    logic             wa_hit;
    logic             wb_hit;

    assign wa_hit = wa_en && (wa_rd != '0);
    assign wb_hit = wb_en && (wb_rd != '0) && !(wa_hit && (wa_rd == wb_rd));

    // Port A source select.
    always_comb begin
        unique case (wb_sel_e'(wa_sel))
            WB_MEM: wa_data = wa_mem;
            WB_ALU: wa_data = wa_alu;
            WB_PC4: wa_data = wa_pc4;
            WB_IMM: wa_data = wa_imm;
        endcase
    end

    // Register storage; port A wins when both ports target one register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            if (wa_hit) regs[wa_rd] <= wa_data;
            if (wb_hit) regs[wb_rd] <= wb_data;
        end
    end

    // Read ports with bypass and load-hazard flags.
    always_comb begin
        logic [AW-1:0] a;
        rs_data = '0;
        rs_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            a = rs_addr[i*AW +: AW];
            if (a == '0)
                rs_data[i*XLEN +: XLEN] = '0;
            else if (BYPASS && wa_en && (wa_rd == a))
                rs_data[i*XLEN +: XLEN] = wa_data;
            else if (BYPASS && wb_en && (wb_rd == a))
                rs_data[i*XLEN +: XLEN] = wb_data;
            else
                rs_data[i*XLEN +: XLEN] = regs[a];
            rs_busy[i] = busy[a] && !(BYPASS && wb_en && (wb_rd == a));
        end
    end

    reg_scoreboard #(
        .NREGS(NREGS)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .iss_en  (iss_en),
        .iss_rd  (iss_rd),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .busy    (busy),
        .iss_busy(iss_busy),
        .pend_cnt(pend_cnt)
    );

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb: reference model plus
// hand-computed checkpoints, bypass and non-bypass instances.
module tb_regfile_bypass_sb;

    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rs_addr;
    logic        wa_en, wb_en, iss_en;
    logic [4:0]  wa_rd, wb_rd, iss_rd;
    logic [1:0]  wa_sel;
    logic [31:0] wa_alu, wa_pc4, wa_imm, wa_mem, wb_data;

    logic [63:0] rd_a, rd_b;
    logic [1:0]  rb_a, rb_b;
    logic        ib_a, ib_b;
    logic [5:0]  pc_a, pc_b;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    regfile_bypass_sb #(.BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rd_a),
        .rs_busy(rb_a), .wa_en(wa_en), .wa_rd(wa_rd), .wa_sel(wa_sel),
        .wa_alu(wa_alu), .wa_pc4(wa_pc4), .wa_imm(wa_imm), .wa_mem(wa_mem),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .iss_en(iss_en),
        .iss_rd(iss_rd), .iss_busy(ib_a), .pend_cnt(pc_a)
    );

    regfile_bypass_sb #(.BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rd_b),
        .rs_busy(rb_b), .wa_en(wa_en), .wa_rd(wa_rd), .wa_sel(wa_sel),
        .wa_alu(wa_alu), .wa_pc4(wa_pc4), .wa_imm(wa_imm), .wa_mem(wa_mem),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .iss_en(iss_en),
        .iss_rd(iss_rd), .iss_busy(ib_b), .pend_cnt(pc_b)
    );

    // Reference model: architectural register values and pending flags.
    logic [31:0] m_reg [32];
    bit          m_busy [32];
    bit          m_ok = 1'b0;

    function automatic logic [31:0] port_a_val();
        case (wa_sel)
            2'd0: return wa_mem;
            2'd1: return wa_alu;
            2'd2: return wa_pc4;
            default: return wa_imm;
        endcase
    endfunction

    function automatic logic [31:0] exp_data(int a, bit byp);
        if (a == 0) return 32'h0;
        if (byp && wa_en && wa_rd == a) return port_a_val();
        if (byp && wb_en && wb_rd == a) return wb_data;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(int a, bit byp);
        return m_busy[a] && !(byp && wb_en && wb_rd == a);
    endfunction

    function automatic int pending();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[r]  <= 32'h0;
                m_busy[r] <= 1'b0;
            end
            m_ok <= 1'b1;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (wa_en && wa_rd == r) m_reg[r] <= port_a_val();
                else if (wb_en && wb_rd == r) m_reg[r] <= wb_data;
                if (iss_en && iss_rd == r) m_busy[r] <= 1'b1;
                else if (wb_en && wb_rd == r) m_busy[r] <= 1'b0;
            end
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!rst && m_ok) begin
            for (int i = 0; i < 2; i++) begin
                int a;
                a = int'(rs_addr[i*AW +: AW]);
                chk($sformatf("a.data%0d", i), rd_a[i*32 +: 32], exp_data(a, 1'b1));
                chk($sformatf("b.data%0d", i), rd_b[i*32 +: 32], exp_data(a, 1'b0));
                chk($sformatf("a.busy%0d", i), 32'(rb_a[i]), 32'(exp_busy(a, 1'b1)));
                chk($sformatf("b.busy%0d", i), 32'(rb_b[i]), 32'(exp_busy(a, 1'b0)));
            end
            chk("a.iss_busy", 32'(ib_a), 32'(m_busy[iss_rd]));
            chk("b.iss_busy", 32'(ib_b), 32'(m_busy[iss_rd]));
            chk("a.pend_cnt", 32'(pc_a), 32'(pending()));
            chk("b.pend_cnt", 32'(pc_b), 32'(pending()));
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        wa_en = 0; wb_en = 0; iss_en = 0;
        wa_rd = 0; wb_rd = 0; iss_rd = 0;
        wa_sel = 2'd1;
    endtask

    task automatic rsel(int p0, int p1);
        rs_addr = {5'(p1), 5'(p0)};
    endtask

    logic [31:0] sel_val [4];

    initial begin
        sel_val[0] = 32'h1111_0000;
        sel_val[1] = 32'h2222_0000;
        sel_val[2] = 32'h0000_0104;
        sel_val[3] = 32'h4444_0000;
        wa_alu = 0; wa_pc4 = 0; wa_imm = 0; wa_mem = 0; wb_data = 0;
        rs_addr = '0;
        idle();
        rst = 1'b1;
        nxt();
        rst = 1'b0;

        // Reset state across every register.
        for (int r = 1; r < 32; r++) begin
            rsel(r, 32 - r);
            settle();
            chk("rst.data0", rd_a[31:0], 32'h0);
            chk("rst.data1", rd_a[63:32], 32'h0);
            nxt();
        end
        chk("rst.busy", 32'(rb_a), 32'h0);
        chk("rst.cnt", 32'(pc_a), 32'h0);

        // Same-cycle bypass on port A.
        wa_en = 1; wa_rd = 5; wa_sel = 2'd1; wa_alu = 32'hDEAD_BEEF;
        rsel(5, 5);
        settle();
        chk("byp.a", rd_a[31:0], 32'hDEAD_BEEF);
        chk("byp.b_old", rd_b[31:0], 32'h0);
        nxt();
        idle();
        settle();
        chk("byp.a_keep", rd_a[31:0], 32'hDEAD_BEEF);
        chk("byp.b_new", rd_b[31:0], 32'hDEAD_BEEF);

        // x0 is hardwired to zero.
        nxt();
        wa_en = 1; wa_rd = 0; wa_sel = 2'd3; wa_imm = 32'h1234;
        rsel(0, 0);
        nxt();
        idle();
        settle();
        chk("x0", rd_a[31:0], 32'h0);

        // Source-select sweep on x7.
        wa_mem = sel_val[0]; wa_alu = sel_val[1];
        wa_pc4 = sel_val[2]; wa_imm = sel_val[3];
        for (int s = 0; s < 4; s++) begin
            nxt();
            wa_en = 1; wa_rd = 7; wa_sel = 2'(s);
            rsel(0, 7);
            nxt();
            idle();
            settle();
            chk($sformatf("sel%0d", s), rd_b[63:32], sel_val[s]);
        end

        // Issue then late return on x9.
        nxt();
        iss_en = 1; iss_rd = 9;
        nxt();
        idle();
        iss_rd = 9;
        rsel(9, 0);
        settle();
        chk("ld.busy", 32'(rb_a[0]), 32'h1);
        chk("ld.iss_busy", 32'(ib_a), 32'h1);
        chk("ld.cnt1", 32'(pc_a), 32'h1);
        nxt();
        wb_en = 1; wb_rd = 9; wb_data = 32'h55;
        settle();
        chk("ld.ret_data", rd_a[31:0], 32'h55);
        chk("ld.ret_busy", 32'(rb_a[0]), 32'h0);
        chk("ld.b_busy", 32'(rb_b[0]), 32'h1);
        nxt();
        idle();
        settle();
        chk("ld.cnt0", 32'(pc_a), 32'h0);

        // Issue and return to the same busy register.
        nxt();
        iss_en = 1; iss_rd = 3;
        nxt();
        iss_en = 1; iss_rd = 3;
        wb_en = 1; wb_rd = 3; wb_data = 32'h77;
        nxt();
        idle();
        rsel(3, 0);
        settle();
        chk("same.busy", 32'(rb_a[0]), 32'h1);
        chk("same.cnt", 32'(pc_a), 32'h1);
        chk("same.data", rd_a[31:0], 32'h77);

        // Both write ports hit x4; port A value is kept.
        nxt();
        wa_en = 1; wa_rd = 4; wa_sel = 2'd1; wa_alu = 32'hAAAA;
        wb_en = 1; wb_rd = 4; wb_data = 32'hBBBB;
        nxt();
        idle();
        rsel(4, 0);
        settle();
        chk("dual.x4", rd_a[31:0], 32'hAAAA);

        // Issue to x0 and re-issue to a busy reg change nothing.
        nxt();
        iss_en = 1; iss_rd = 0;
        nxt();
        iss_en = 1; iss_rd = 3;
        nxt();
        idle();
        settle();
        chk("idem.cnt", 32'(pc_a), 32'h1);

        // Retire x3, then three loads in flight and a mid-flight reset.
        nxt();
        wb_en = 1; wb_rd = 3; wb_data = 32'h1;
        nxt();
        idle();
        for (int r = 10; r < 13; r++) begin
            iss_en = 1; iss_rd = 5'(r);
            nxt();
        end
        idle();
        settle();
        chk("fly.cnt3", 32'(pc_a), 32'h3);
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        rsel(10, 5);
        settle();
        chk("rst2.cnt", 32'(pc_a), 32'h0);
        chk("rst2.busy", 32'(rb_a), 32'h0);
        chk("rst2.x5", rd_a[63:32], 32'h0);
        nxt();
        wb_en = 1; wb_rd = 10; wb_data = 32'h99;
        nxt();
        idle();
        rsel(10, 11);
        settle();
        chk("late.cnt", 32'(pc_a), 32'h0);
        chk("late.x10", rd_a[31:0], 32'h99);

        nxt();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
